// File: rtl/ula_pkg.sv
// Shared types and active-low (gfedcba) segment patterns for the ULA result display.
package ula_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    DESLOCA  = 2'd1,
    ATUALIZA = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    SEL_NUM = 2'd0,
    SEL_E   = 2'd1,
    SEL_R   = 2'd2
  } sel_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_r     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_digito(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_para_7seg.sv
// Combinational BCD nibble to 7-segment decoder with blanking and "E"/"r" overrides.
module bcd_para_7seg
  import ula_pkg::*;
#(
  parameter bit SEG_ATIVO_BAIXO = 1'b1
) (
  input  logic [3:0] digito_i,
  input  logic       apaga_i,
  input  sel_t       sel_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_baixo;

  always_comb begin
    seg_baixo = SEG_BLANK;
    case (sel_i)
      SEL_E:   seg_baixo = SEG_E;
      SEL_R:   seg_baixo = SEG_r;
      default: seg_baixo = apaga_i ? SEG_BLANK : seg_digito(digito_i);
    endcase
    seg_o = SEG_ATIVO_BAIXO ? seg_baixo : ~seg_baixo;
  end

endmodule

// File: rtl/ula_resultado_display.sv
// Captures the ULA result and flags on Load, converts to BCD by shift-add-3 (one bit per
// cycle) and registers the three 7-segment displays and flag LEDs once the conversion ends.
module ula_resultado_display
  import ula_pkg::*;
#(
  parameter int LARGURA         = 8,
  parameter int DIGITOS         = 3,
  parameter bit SEG_ATIVO_BAIXO = 1'b1,
  parameter bit BLANK_LZ        = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [LARGURA-1:0] S,
  input  logic               Z,
  input  logic               OV,
  input  logic               COUT,
  input  logic               ERR,
  input  logic               Load,
  output logic               Busy,
  output logic               Done,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [3:0]         LEDR
);

  localparam int BCD_W = 4 * DIGITOS;
  localparam int CNT_W = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ATIVO_BAIXO ? 7'h7F : 7'h00;

  estado_t            estado_q;
  logic [LARGURA-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         flags_q;
  logic               pend_q, busy_q, done_q;
  logic [6:0]         hex0_q, hex1_q, hex2_q;
  logic [3:0]         ledr_q;
  logic               captura;
  logic [6:0]         seg0, seg1, seg2;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITOS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  assign {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;

  // A pending (or simultaneous) Load at ATUALIZA chains straight into the next capture.
  assign captura = ((estado_q == OCIOSO) && Load) ||
                   ((estado_q == ATUALIZA) && (Load || pend_q));

  logic [3:0] cent, dez, uni;
  logic       erro;
  assign cent = bcd_q[11:8];
  assign dez  = bcd_q[7:4];
  assign uni  = bcd_q[3:0];
  assign erro = flags_q[3];

  bcd_para_7seg #(.SEG_ATIVO_BAIXO(SEG_ATIVO_BAIXO)) u_hex2 (
    .digito_i (cent),
    .apaga_i  (BLANK_LZ && (cent == 4'd0)),
    .sel_i    (erro ? SEL_E : SEL_NUM),
    .seg_o    (seg2)
  );

  bcd_para_7seg #(.SEG_ATIVO_BAIXO(SEG_ATIVO_BAIXO)) u_hex1 (
    .digito_i (dez),
    .apaga_i  (BLANK_LZ && (cent == 4'd0) && (dez == 4'd0)),
    .sel_i    (erro ? SEL_R : SEL_NUM),
    .seg_o    (seg1)
  );

  bcd_para_7seg #(.SEG_ATIVO_BAIXO(SEG_ATIVO_BAIXO)) u_hex0 (
    .digito_i (uni),
    .apaga_i  (1'b0),
    .sel_i    (erro ? SEL_R : SEL_NUM),
    .seg_o    (seg0)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      estado_q <= OCIOSO;
      sh_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      flags_q  <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ledr_q   <= '0;
      hex0_q   <= SEG_OFF;
      hex1_q   <= SEG_OFF;
      hex2_q   <= SEG_OFF;
    end else begin
      done_q <= 1'b0;
      case (estado_q)
        OCIOSO: ;
        DESLOCA: begin
          bcd_q <= bcd_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (Load) pend_q <= 1'b1;
          if (cnt_q == CNT_W'(LARGURA - 1)) estado_q <= ATUALIZA;
        end
        ATUALIZA: begin
          hex0_q   <= seg0;
          hex1_q   <= seg1;
          hex2_q   <= seg2;
          ledr_q   <= flags_q;
          done_q   <= 1'b1;
          pend_q   <= 1'b0;
          busy_q   <= 1'b0;
          estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
      if (captura) begin
        sh_q     <= S;
        flags_q  <= {ERR, COUT, OV, Z};
        bcd_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
        estado_q <= DESLOCA;
      end
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;
  assign LEDR = ledr_q;

endmodule

// File: tb/tb_ula_resultado_display.sv
// Directed bench for ula_resultado_display: vector table plus pending, held-Load and reset-abort sequences.
module tb_ula_resultado_display;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] S;
  logic       Z, OV, COUT, ERR, Load;
  logic       Busy, Done;
  logic [6:0] HEX0, HEX1, HEX2;
  logic [3:0] LEDR;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] LE = 7'b0000110;
  localparam logic [6:0] LR = 7'b0101111;

  ula_resultado_display dut (
    .Clk(Clk), .Rst(Rst), .S(S), .Z(Z), .OV(OV), .COUT(COUT), .ERR(ERR), .Load(Load),
    .Busy(Busy), .Done(Done), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .LEDR(LEDR)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] s;
    logic [3:0] fl;   // {ERR,COUT,OV,Z}
    logic [6:0] h2, h1, h0;
    logic [3:0] ledr;
  } vet_t;

  vet_t vets[7];

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nome, act, exp);
    end
  endtask

  task automatic conv(input vet_t v);
    int n;
    S = v.s;
    {ERR, COUT, OV, Z} = v.fl;
    Load = 1'b1;
    @(posedge Clk); #1;
    Load = 1'b0;
    S = ~v.s;
    {ERR, COUT, OV, Z} = ~v.fl;
    chk("busy_after_load", Busy, 1);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge Clk); #1;
      if (Done) begin n = i; break; end
    end
    chk("latency", n, 9);
    chk("hex2", HEX2, v.h2);
    chk("hex1", HEX1, v.h1);
    chk("hex0", HEX0, v.h0);
    chk("ledr", LEDR, v.ledr);
    chk("busy_after_done", Busy, 0);
    @(posedge Clk); #1;
    chk("done_one_cycle", Done, 0);
  endtask

  initial begin
    int nd, extra;
    vets[0] = '{8'd255, 4'b0000, D2, D5, D5, 4'b0000};
    vets[1] = '{8'd0,   4'b0001, B,  B,  D0, 4'b0001};
    vets[2] = '{8'd100, 4'b0100, D1, D0, D0, 4'b0100};
    vets[3] = '{8'd0,   4'b1000, LE, LR, LR, 4'b1000};
    vets[4] = '{8'd10,  4'b0010, B,  D1, D0, 4'b0010};
    vets[5] = '{8'd37,  4'b0000, B,  D3, D7, 4'b0000};
    vets[6] = '{8'd205, 4'b1111, LE, LR, LR, 4'b1111};

    Rst = 1'b1; Load = 1'b0; S = '0; {ERR, COUT, OV, Z} = 4'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_ledr", LEDR, 0);
    chk("rst_hex", {HEX2, HEX1, HEX0}, {B, B, B});
    Rst = 1'b0;
    @(posedge Clk); #1;

    for (int i = 0; i < 7; i++) conv(vets[i]);

    // Second Load during a conversion is held pending and chains into the next one.
    S = 8'd37; {ERR, COUT, OV, Z} = 4'b0; Load = 1'b1;
    @(posedge Clk); #1;
    Load = 1'b0;
    nd = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge Clk); #1;
      if (Done) begin
        nd++;
        if (nd == 1) begin
          chk("pend_first_at", n, 9);
          chk("pend_first_val", {HEX2, HEX1, HEX0}, {B, D3, D7});
        end else if (nd == 2) begin
          chk("pend_second_at", n, 18);
          chk("pend_second_val", {HEX2, HEX1, HEX0}, {B, D4, D2});
        end
      end
      if (n == 9) chk("pend_busy_kept", Busy, 1);
      Load = (n == 2);
      if (n == 2) S = 8'd42;
    end
    chk("pend_done_count", nd, 2);
    chk("pend_idle", Busy, 0);

    // Load held high: one conversion per 9 cycles.
    S = 8'd255; Load = 1'b1;
    nd = 0;
    for (int n = 1; n <= 28; n++) begin
      @(posedge Clk); #1;
      if (Done) nd++;
    end
    Load = 1'b0;
    chk("held_done_count", nd, 3);
    chk("held_val", {HEX2, HEX1, HEX0}, {D2, D5, D5});
    extra = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge Clk); #1;
      if (Done) extra++;
    end
    chk("held_tail_done", extra, 1);
    chk("held_tail_idle", Busy, 0);

    // Reset mid-conversion aborts to blank displays with no Done.
    S = 8'd200; Load = 1'b1;
    @(posedge Clk); #1;
    Load = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_hex", {HEX2, HEX1, HEX0}, {B, B, B});
    chk("abort_ledr", LEDR, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    nd = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge Clk); #1;
      if (Done) nd++;
    end
    chk("abort_no_done", nd, 0);
    conv('{8'd7, 4'b0000, B, B, D7, 4'b0000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
